// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver. It consumes one-clock s_tick pulses (16 per
// bit), samples each bit mid-period and delivers DBIT data bits LSB first.
// Each frame ends with a one-cycle done strobe and a stop-bit framing flag.
module uart_rx_os16 #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);

  localparam int CW = (SB_TICK > 16) ? 5 : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [CW-1:0] CNT_MID  = CW'(7);
  localparam logic [CW-1:0] CNT_BIT  = CW'(15);
  localparam logic [CW-1:0] CNT_STOP = CW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST   = NW'(DBIT - 1);
  // With a single stop bit the stop sample and the frame end share one tick,
  // so the live line value is used instead of the captured one.
  localparam logic STOP_DIRECT = (SB_TICK == 16);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [1:0]      sync_r;
  logic            rx_s;
  state_t          state_r, state_nxt;
  logic [CW-1:0]   s_cnt_r, s_cnt_nxt;
  logic [NW-1:0]   n_r, n_nxt;
  logic [DBIT-1:0] b_r, b_nxt;
  logic            stop_r, stop_nxt;
  logic [DBIT-1:0] dout_nxt;
  logic            done_nxt;
  logic            ferr_nxt;
  logic            busy_nxt;

  assign rx_s = sync_r[1];

  // State, datapath and output registers, including the rx synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r       <= 2'b11;
      state_r      <= IDLE;
      s_cnt_r      <= '0;
      n_r          <= '0;
      b_r          <= '0;
      stop_r       <= 1'b0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sync_r       <= {sync_r[0], rx};
      state_r      <= state_nxt;
      s_cnt_r      <= s_cnt_nxt;
      n_r          <= n_nxt;
      b_r          <= b_nxt;
      stop_r       <= stop_nxt;
      dout         <= dout_nxt;
      rx_done_tick <= done_nxt;
      frame_err    <= ferr_nxt;
      busy         <= busy_nxt;
    end
  end

  // Next-state and next-output logic; only IDLE->START moves without a tick.
  always_comb begin
    state_nxt = state_r;
    s_cnt_nxt = s_cnt_r;
    n_nxt     = n_r;
    b_nxt     = b_r;
    stop_nxt  = stop_r;
    dout_nxt  = dout;
    ferr_nxt  = frame_err;
    done_nxt  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          s_cnt_nxt = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_r == CNT_MID) begin
            if (!rx_s) begin
              state_nxt = DATA;
              s_cnt_nxt = '0;
              n_nxt     = '0;
            end else begin
              // Line went back high by mid start bit: glitch, not a frame.
              state_nxt = IDLE;
            end
          end else begin
            s_cnt_nxt = s_cnt_r + CW'(1);
          end
        end else begin
          state_nxt = START;
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_r == CNT_BIT) begin
            s_cnt_nxt = '0;
            b_nxt     = {rx_s, b_r[DBIT-1:1]};
            if (n_r == N_LAST) begin
              state_nxt = STOP;
            end else begin
              n_nxt = n_r + NW'(1);
            end
          end else begin
            s_cnt_nxt = s_cnt_r + CW'(1);
          end
        end else begin
          state_nxt = DATA;
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt_r == CNT_BIT) begin
            stop_nxt = rx_s;
          end else begin
            stop_nxt = stop_r;
          end
          if (s_cnt_r == CNT_STOP) begin
            state_nxt = IDLE;
            dout_nxt  = b_r;
            ferr_nxt  = STOP_DIRECT ? ~rx_s : ~stop_r;
            done_nxt  = 1'b1;
          end else begin
            s_cnt_nxt = s_cnt_r + CW'(1);
          end
        end else begin
          state_nxt = STOP;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: one instance with one stop bit and one with two.
// Frames come from a vector table; expected words go into per-instance queues
// and are popped when each done strobe appears.
module tb_uart_rx_os16;

  localparam int TP = 8;  // clk cycles per s_tick

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       rx16, rx32;
  logic [7:0] dout16, dout32;
  logic       done16, done32, ferr16, ferr32, busy16, busy32;

  int checks = 0;
  int failures = 0;
  int strobes16 = 0, strobes32 = 0;
  int exp16 = 0, exp32 = 0;
  logic [8:0] q16[$];
  logic [8:0] q32[$];

  typedef struct {
    logic       inst;      // 0: one stop bit instance, 1: two stop bits
    logic [7:0] data;
    logic       stop_ok;
    int         gap_bits;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  uart_rx_os16 #(.DBIT(8), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .rx(rx16), .s_tick(s_tick),
    .dout(dout16), .rx_done_tick(done16), .frame_err(ferr16), .busy(busy16)
  );

  uart_rx_os16 #(.DBIT(8), .SB_TICK(32)) dut32 (
    .clk(clk), .reset(reset), .rx(rx32), .s_tick(s_tick),
    .dout(dout32), .rx_done_tick(done32), .frame_err(ferr32), .busy(busy32)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * TP) @(negedge clk);
  endtask

  task automatic drive(input logic inst, input logic v);
    if (inst) rx32 = v;
    else rx16 = v;
  endtask

  task automatic send_frame(input logic inst, input logic [7:0] d, input logic stop_ok,
                            input int gap_bits, input logic [7:0] exp_d, input logic exp_f);
    if (inst) begin
      q32.push_back({exp_f, exp_d});
      exp32++;
    end else begin
      q16.push_back({exp_f, exp_d});
      exp16++;
    end
    drive(inst, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      drive(inst, d[i]);
      wait_ticks(16);
    end
    if (stop_ok) begin
      drive(inst, 1'b1);
      wait_ticks(16);
    end else begin
      drive(inst, 1'b0);
      wait_ticks(12);
      drive(inst, 1'b1);
      wait_ticks(4);
    end
    if (inst) wait_ticks(16);
    wait_ticks(16 * gap_bits);
  endtask

  // s_tick: one clk high every TP clks
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (TP - 1) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  // Scoreboard: every done strobe pops one expected word per instance
  always @(negedge clk) begin : mon
    logic [8:0] e;
    if (done16 === 1'b1) begin
      strobes16++;
      if (q16.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done16 dout=%0h", dout16);
      end else begin
        e = q16.pop_front();
        check("dout16", dout16, e[7:0]);
        check("ferr16", ferr16, e[8]);
        check("busy16_at_done", busy16, 1'b0);
      end
    end
    if (done32 === 1'b1) begin
      strobes32++;
      if (q32.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done32 dout=%0h", dout32);
      end else begin
        e = q32.pop_front();
        check("dout32", dout32, e[7:0]);
        check("ferr32", ferr32, e[8]);
        check("busy32_at_done", busy32, 1'b0);
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #(200000 * 10);
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 1'b1, 1, 8'hA5, 1'b0};
    vecs[1] = '{1'b0, 8'h3C, 1'b0, 2, 8'h3C, 1'b1};
    vecs[2] = '{1'b0, 8'h81, 1'b1, 1, 8'h81, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 0, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 8'hFF, 1'b1, 1, 8'hFF, 1'b0};
    vecs[5] = '{1'b1, 8'h00, 1'b1, 0, 8'h00, 1'b0};
    vecs[6] = '{1'b1, 8'hFF, 1'b1, 0, 8'hFF, 1'b0};
    vecs[7] = '{1'b1, 8'h5A, 1'b1, 1, 8'h5A, 1'b0};

    // Reset with the line held low
    reset = 1'b1;
    rx16  = 1'b0;
    rx32  = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_dout16", dout16, 8'h00);
    check("rst_done16", done16, 1'b0);
    check("rst_ferr16", ferr16, 1'b0);
    check("rst_busy16", busy16, 1'b0);
    check("rst_dout32", dout32, 8'h00);
    check("rst_busy32", busy32, 1'b0);
    reset = 1'b0;
    rx16  = 1'b1;
    rx32  = 1'b1;
    repeat (40) @(negedge clk);
    check("idle_busy16", busy16, 1'b0);
    check("idle_busy32", busy32, 1'b0);

    // Table-driven frames; outputs must hold until the next strobe
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].inst, vecs[i].data, vecs[i].stop_ok, vecs[i].gap_bits,
                 vecs[i].exp_data, vecs[i].exp_ferr);
      check("hold_dout", vecs[i].inst ? dout32 : dout16, vecs[i].exp_data);
      check("hold_ferr", vecs[i].inst ? ferr32 : ferr16, vecs[i].exp_ferr);
    end

    // False start: busy rises 3 clk after rx falls, then drops with no strobe
    rx16 = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_not_yet", busy16, 1'b0);
    @(negedge clk);
    check("busy_rise", busy16, 1'b1);
    repeat (3 * TP - 3) @(negedge clk);
    rx16 = 1'b1;
    wait_ticks(16);
    check("false_start_busy", busy16, 1'b0);
    check("false_start_dout", dout16, 8'hFF);
    check("false_start_ferr", ferr16, 1'b0);

    // Reset during data bit 4 of 0x55
    rx16 = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx16 = (i % 2 == 0) ? 1'b1 : 1'b0;
      wait_ticks(16);
    end
    rx16 = 1'b1;
    wait_ticks(8);
    check("mid_frame_busy", busy16, 1'b1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy16", busy16, 1'b0);
    reset = 1'b0;
    wait_ticks(32);
    check("after_reset_busy", busy16, 1'b0);
    check("after_reset_dout", dout16, 8'h00);
    send_frame(1'b0, 8'h96, 1'b1, 1, 8'h96, 1'b0);

    // Drain scoreboard with a bounded wait
    for (int k = 0; k < 2000; k++) begin
      if (q16.size() == 0 && q32.size() == 0) break;
      @(negedge clk);
    end
    check("q16_drained", q16.size(), 0);
    check("q32_drained", q32.size(), 0);
    check("strobes16", strobes16, exp16);
    check("strobes32", strobes32, exp32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
